sram_arbiter: RTL and testbench
===============================

SRAM_ARBITER -- requirements
Module: sram_arbiter

Interface
REQ-001 SHALL have parameter ACCESS_CYCLES, default 2: cycles OE/WE held per access, legal 1..15.
REQ-002 SHALL have port Clk  in  1  system clock; all state changes on rising edge.
REQ-003 SHALL have port Reset  in  1  reset, asynchronous, active-low.
REQ-004 SHALL have port cpu_req  in  1  CPU (MAR/MDR side) access request.
REQ-005 SHALL have port cpu_we  in  1  CPU request is write (1) / read (0).
REQ-006 SHALL have port cpu_addr  in  16  CPU address.
REQ-007 SHALL have port cpu_wdata  in  16  CPU write data.
REQ-008 SHALL have port cpu_rdata  out  16  last CPU read result.
REQ-009 SHALL have port cpu_done  out  1  one-cycle CPU completion pulse.
REQ-010 SHALL have ports dma_req, dma_we, dma_addr, dma_wdata, dma_rdata and dma_done, with the same direction, width and meaning as the CPU ports, for the program-loader/debug requester.
REQ-011 SHALL have port ADDR  out  16  SRAM address.
REQ-012 SHALL have port Data_to_SRAM  out  16  SRAM write data.
REQ-013 SHALL have port Data_from_SRAM  in  16  SRAM read data.
REQ-014 SHALL have ports OE and WE  out  1  active-high SRAM read enable and write enable.
REQ-015 SHALL have port owner  out  1  current or last grantee: 0 = CPU, 1 = DMA.
REQ-016 SHALL have port busy  out  1  high in ACCESS and COMPLETE.

Function
REQ-017 SHALL implement FSM IDLE -> ACCESS -> COMPLETE -> IDLE; no other states.
REQ-018 IDLE: requests SHALL be sampled only here; with no request, stay in IDLE.
REQ-019 On a grant in IDLE, SHALL latch the winner's addr, wdata and we into ADDR/Data_to_SRAM/internal we, set owner, load the down-counter with ACCESS_CYCLES, and move to ACCESS.
REQ-020 Arbitration SHALL be round-robin. A single requester wins. On a tie, the port not equal to last_owner wins.
REQ-021 ACCESS: OE=1 for reads, or WE=1 for writes, exactly ACCESS_CYCLES cycles; then move to COMPLETE.
REQ-022 OE and WE SHALL be registered outputs, never high together, and both 0 outside ACCESS.
REQ-023 For a read, the edge leaving ACCESS SHALL capture Data_from_SRAM into the owner's rdata.
REQ-024 Each rdata SHALL hold its value until that port's next read completes; writes SHALL leave rdata unchanged.
REQ-025 COMPLETE SHALL last one cycle: owner's done=1, last_owner<=owner, next state IDLE.
REQ-026 Latency: req sampled at edge N SHALL give done high in cycle N+ACCESS_CYCLES+1.
REQ-027 A req dropped after grant SHALL NOT abort the access; done still pulses.
REQ-028 The losing requester's inputs SHALL be ignored until its own grant.
REQ-029 A req still high in the IDLE following done SHALL count as a new request (back-to-back allowed).
REQ-030 ADDR and Data_to_SRAM SHALL hold their last granted values while in IDLE.
REQ-031 Starvation bound: a held request SHALL be granted after at most one other transaction.

Reset
REQ-032 Reset=0 SHALL immediately, without waiting for a clock edge, force: state IDLE, OE=WE=0, cpu_done=dma_done=0, busy=0, owner=0, ADDR=Data_to_SRAM=0, cpu_rdata=dma_rdata=0, counter 0, last_owner=1 (CPU wins the first tie).
REQ-033 Reset asserted mid-access SHALL abort the access: no done pulse and no rdata update. After Reset returns to 1, operation SHALL restart from IDLE.

Verification
REQ-034 CPU read: cpu_req=1, cpu_we=0, cpu_addr=0x0010 at edge 0, SRAM returns 0xBEEF -> ADDR=0x0010, OE=1 in cycles 1-2, WE=0, cpu_done=1 in cycle 3, cpu_rdata=0xBEEF.
REQ-035 DMA write: dma_addr=0x0200, dma_wdata=0x1234, dma_we=1 -> WE=1 for 2 cycles with ADDR=0x0200 and Data_to_SRAM=0x1234, OE=0, dma_done in cycle 3, dma_rdata unchanged.
REQ-036 Tie after reset, both req high at edge 0 -> CPU served with cpu_done in cycle 3. DMA sampled at edge 4, owner=1, dma_done in cycle 7.
REQ-037 Both req held high for 4 transactions -> owner sequence 0,1,0,1; done pulses alternate; no port is served twice in a row.
REQ-038 Reset=0 in cycle 1 of a CPU write -> WE falls with no clock edge, no cpu_done. After release, busy=0 and a fresh read completes normally.
REQ-039 cpu_req dropped in cycle 1 of a read, with ACCESS_CYCLES=4 -> OE high in cycles 1-4, cpu_done in cycle 5, read data captured.

Source files
------------

// File: rtl/sram_arbiter.sv
`timescale 1ns/1ps
// Round-robin arbiter giving a CPU port and a DMA/loader port shared access to one SRAM.
// Every grant walks IDLE -> ACCESS (ACCESS_CYCLES long) -> COMPLETE -> IDLE.
module sram_arbiter #(
   parameter int unsigned ACCESS_CYCLES = 2
) (
   input  logic        Clk,
   input  logic        Reset,
   input  logic        cpu_req,
   input  logic        cpu_we,
   input  logic [15:0] cpu_addr,
   input  logic [15:0] cpu_wdata,
   output logic [15:0] cpu_rdata,
   output logic        cpu_done,
   input  logic        dma_req,
   input  logic        dma_we,
   input  logic [15:0] dma_addr,
   input  logic [15:0] dma_wdata,
   output logic [15:0] dma_rdata,
   output logic        dma_done,
   output logic [15:0] ADDR,
   output logic [15:0] Data_to_SRAM,
   input  logic [15:0] Data_from_SRAM,
   output logic        OE,
   output logic        WE,
   output logic        owner,
   output logic        busy
);

   localparam logic [1:0] S_IDLE     = 2'd0;
   localparam logic [1:0] S_ACCESS   = 2'd1;
   localparam logic [1:0] S_COMPLETE = 2'd2;
   localparam logic [3:0] CNT_LOAD   = 4'(ACCESS_CYCLES);

   logic [1:0]  state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic        owner_q, owner_d;
   logic        last_owner_q, last_owner_d;
   logic        we_q, we_d;
   logic [15:0] addr_q, addr_d;
   logic [15:0] wdata_q, wdata_d;
   logic        oe_q, oe_d;
   logic        wen_q, wen_d;
   logic [15:0] cpu_rdata_q, cpu_rdata_d;
   logic [15:0] dma_rdata_q, dma_rdata_d;
   logic        cpu_done_q, cpu_done_d;
   logic        dma_done_q, dma_done_d;
   logic        grant_dma;

   // On a tie the port that was not served last wins.
   assign grant_dma = dma_req && (!cpu_req || !last_owner_q);

   // NOTE: every always_comb output gets its default first, so no path can infer a latch.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      owner_d      = owner_q;
      last_owner_d = last_owner_q;
      we_d         = we_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      oe_d         = oe_q;
      wen_d        = wen_q;
      cpu_rdata_d  = cpu_rdata_q;
      dma_rdata_d  = dma_rdata_q;
      cpu_done_d   = 1'b0;
      dma_done_d   = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (cpu_req || dma_req) begin
               owner_d = grant_dma;
               we_d    = grant_dma ? dma_we    : cpu_we;
               addr_d  = grant_dma ? dma_addr  : cpu_addr;
               wdata_d = grant_dma ? dma_wdata : cpu_wdata;
               oe_d    = !(grant_dma ? dma_we : cpu_we);
               wen_d   =   grant_dma ? dma_we : cpu_we;
               cnt_d   = CNT_LOAD;
               state_d = S_ACCESS;
            end
         end
         S_ACCESS: begin
            if (cnt_q <= 4'd1) begin
               cnt_d   = 4'd0;
               oe_d    = 1'b0;
               wen_d   = 1'b0;
               state_d = S_COMPLETE;
               if (!we_q) begin
                  if (owner_q) dma_rdata_d = Data_from_SRAM;
                  else         cpu_rdata_d = Data_from_SRAM;
               end
               // Done is registered here so it is high exactly during COMPLETE.
               cpu_done_d = !owner_q;
               dma_done_d =  owner_q;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         S_COMPLETE: begin
            last_owner_d = owner_q;
            state_d      = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge Clk or negedge Reset) begin
      if (!Reset) begin
         state_q      <= S_IDLE;
         cnt_q        <= 4'd0;
         owner_q      <= 1'b0;
         last_owner_q <= 1'b1;
         we_q         <= 1'b0;
         addr_q       <= 16'h0000;
         wdata_q      <= 16'h0000;
         oe_q         <= 1'b0;
         wen_q        <= 1'b0;
         cpu_rdata_q  <= 16'h0000;
         dma_rdata_q  <= 16'h0000;
         cpu_done_q   <= 1'b0;
         dma_done_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         owner_q      <= owner_d;
         last_owner_q <= last_owner_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
         oe_q         <= oe_d;
         wen_q        <= wen_d;
         cpu_rdata_q  <= cpu_rdata_d;
         dma_rdata_q  <= dma_rdata_d;
         cpu_done_q   <= cpu_done_d;
         dma_done_q   <= dma_done_d;
      end
   end

   assign ADDR         = addr_q;
   assign Data_to_SRAM = wdata_q;
   assign OE           = oe_q;
   assign WE           = wen_q;
   assign owner        = owner_q;
   assign busy         = (state_q != S_IDLE);
   assign cpu_rdata    = cpu_rdata_q;
   assign dma_rdata    = dma_rdata_q;
   assign cpu_done     = cpu_done_q;
   assign dma_done     = dma_done_q;

endmodule

// File: tb/tb_sram_arbiter.sv
`timescale 1ns/1ps
// Directed bench for sram_arbiter: a scoreboard of expected completions is filled as
// requests are driven and drained as done pulses appear; a second instance uses ACCESS_CYCLES=4.
module tb_sram_arbiter;

   typedef struct {
      logic        port;
      logic        is_wr;
      logic [15:0] addr;
      logic [15:0] wdata;
      logic [15:0] rdata;
   } exp_t;

   logic        Clk = 1'b0;
   logic        Reset;
   logic        cpu_req, cpu_we, dma_req, dma_we;
   logic [15:0] cpu_addr, cpu_wdata, dma_addr, dma_wdata;
   logic        sel;

   logic [15:0] cpu_rdata, dma_rdata, ADDR, Data_to_SRAM, Data_from_SRAM;
   logic        cpu_done, dma_done, OE, WE, owner, busy;
   logic [15:0] cpu_rdata4, dma_rdata4, addr4, dts4, dfs4;
   logic        cpu_done4, dma_done4, oe4, we4, owner4, busy4;

   logic [15:0] m_cpu_rdata, m_dma_rdata, m_addr, m_dts;
   logic        m_cpu_done, m_dma_done, m_oe, m_we, m_owner, m_busy;

   bit [15:0] mem   [1024];
   bit        wr_ok [1024];

   exp_t        sb_q[$];
   int          errors = 0;
   int          checks = 0;
   logic [15:0] exp_cpu_rd, exp_dma_rd;

   always #5 Clk = ~Clk;

   function automatic logic [15:0] sram_pat(input logic [15:0] a);
      return (a == 16'h0010) ? 16'hBEEF : {a[7:0] ^ 8'h5A, ~a[7:0]};
   endfunction

   always @(posedge Clk) begin
      if (WE) begin
         mem[ADDR[9:0]]   <= Data_to_SRAM;
         wr_ok[ADDR[9:0]] <= 1'b1;
      end
   end
   assign Data_from_SRAM = wr_ok[ADDR[9:0]] ? mem[ADDR[9:0]] : sram_pat(ADDR);
   assign dfs4           = sram_pat(addr4);

   assign m_cpu_rdata = sel ? cpu_rdata4 : cpu_rdata;
   assign m_dma_rdata = sel ? dma_rdata4 : dma_rdata;
   assign m_addr      = sel ? addr4      : ADDR;
   assign m_dts       = sel ? dts4       : Data_to_SRAM;
   assign m_cpu_done  = sel ? cpu_done4  : cpu_done;
   assign m_dma_done  = sel ? dma_done4  : dma_done;
   assign m_oe        = sel ? oe4        : OE;
   assign m_we        = sel ? we4        : WE;
   assign m_owner     = sel ? owner4     : owner;
   assign m_busy      = sel ? busy4      : busy;

   sram_arbiter #(.ACCESS_CYCLES(2)) u_dut (
      .Clk(Clk), .Reset(Reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata), .cpu_done(cpu_done),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_rdata(dma_rdata), .dma_done(dma_done),
      .ADDR(ADDR), .Data_to_SRAM(Data_to_SRAM), .Data_from_SRAM(Data_from_SRAM),
      .OE(OE), .WE(WE), .owner(owner), .busy(busy)
   );

   sram_arbiter #(.ACCESS_CYCLES(4)) u_dut4 (
      .Clk(Clk), .Reset(Reset),
      .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_rdata(cpu_rdata4), .cpu_done(cpu_done4),
      .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr), .dma_wdata(dma_wdata),
      .dma_rdata(dma_rdata4), .dma_done(dma_done4),
      .ADDR(addr4), .Data_to_SRAM(dts4), .Data_from_SRAM(dfs4),
      .OE(oe4), .WE(we4), .owner(owner4), .busy(busy4)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   task automatic fail(input string tag);
      checks++;
      errors++;
      $error("FAIL %s: observed=none expected=event", tag);
   endtask

   task automatic push(input logic port, input logic is_wr,
                       input logic [15:0] addr, input logic [15:0] wdata);
      exp_t e;
      e.port  = port;
      e.is_wr = is_wr;
      e.addr  = addr;
      e.wdata = wdata;
      if (!is_wr) begin
         if (port) exp_dma_rd = sram_pat(addr);
         else      exp_cpu_rd = sram_pat(addr);
      end
      e.rdata = port ? exp_dma_rd : exp_cpu_rd;
      sb_q.push_back(e);
   endtask

   task automatic drive(input logic port, input logic is_wr,
                        input logic [15:0] addr, input logic [15:0] wdata);
      if (port) begin
         dma_we = is_wr; dma_addr = addr; dma_wdata = wdata; dma_req = 1'b1;
      end else begin
         cpu_we = is_wr; cpu_addr = addr; cpu_wdata = wdata; cpu_req = 1'b1;
      end
   endtask

   // Called in the cycle the request is (or will be) visible in IDLE; ends in the IDLE cycle after done.
   task automatic wait_done(input string tag, input logic [1:0] drop, input int unsigned ac);
      exp_t        e;
      int unsigned n, oe_n, we_n, both_n;
      bit          seen, got;
      if (sb_q.size() == 0) begin
         fail({tag, "_sb_empty"});
         return;
      end
      e = sb_q.pop_front();
      n = 0; oe_n = 0; we_n = 0; both_n = 0; seen = 0; got = 0;
      while (!got && n < 20) begin
         @(negedge Clk);
         n++;
         if (n == 1) begin
            if (drop[0]) cpu_req = 1'b0;
            if (drop[1]) dma_req = 1'b0;
         end
         if (m_oe) oe_n++;
         if (m_we) we_n++;
         if (m_oe && m_we) both_n++;
         if (!seen && (m_oe || m_we)) begin
            seen = 1;
            check({tag, "_addr"}, 32'(m_addr), 32'(e.addr));
            if (e.is_wr) check({tag, "_wdata"}, 32'(m_dts), 32'(e.wdata));
         end
         got = m_cpu_done || m_dma_done;
      end
      if (!got) begin
         fail({tag, "_timeout"});
         return;
      end
      check({tag, "_latency"}, 32'(n), 32'(ac + 1));
      check({tag, "_oe_cycles"}, 32'(oe_n), e.is_wr ? 32'd0 : 32'(ac));
      check({tag, "_we_cycles"}, 32'(we_n), e.is_wr ? 32'(ac) : 32'd0);
      check({tag, "_oe_we_overlap"}, 32'(both_n), 32'd0);
      check({tag, "_owner"}, 32'(m_owner), 32'(e.port));
      check({tag, "_done"}, {30'd0, m_dma_done, m_cpu_done}, e.port ? 32'd2 : 32'd1);
      check({tag, "_rdata"}, 32'(e.port ? m_dma_rdata : m_cpu_rdata), 32'(e.rdata));
      @(negedge Clk);
      check({tag, "_idle_after"}, {29'd0, m_busy, m_dma_done, m_cpu_done}, 32'd0);
   endtask

   task automatic pulse_reset();
      @(negedge Clk);
      Reset = 1'b0;
      @(negedge Clk);
      Reset = 1'b1;
      exp_cpu_rd = 16'h0000;
      exp_dma_rd = 16'h0000;
      @(negedge Clk);
   endtask

   initial begin
      int unsigned done_seen;
      sel = 1'b0;
      cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = 16'h0000; cpu_wdata = 16'h0000;
      dma_req = 1'b0; dma_we = 1'b0; dma_addr = 16'h0000; dma_wdata = 16'h0000;
      exp_cpu_rd = 16'h0000;
      exp_dma_rd = 16'h0000;
      Reset = 1'b1;
      #1 Reset = 1'b0;
      #1;
      check("rst_oe_we",    {30'd0, WE, OE}, 32'd0);
      check("rst_done",     {30'd0, dma_done, cpu_done}, 32'd0);
      check("rst_busy",     32'(busy), 32'd0);
      check("rst_owner",    32'(owner), 32'd0);
      check("rst_addr",     32'(ADDR), 32'd0);
      check("rst_wdata",    32'(Data_to_SRAM), 32'd0);
      check("rst_rdata",    {cpu_rdata, dma_rdata}, 32'd0);
      repeat (2) @(negedge Clk);
      Reset = 1'b1;
      @(negedge Clk);

      // CPU read of 0x0010 returning 0xBEEF.
      drive(1'b0, 1'b0, 16'h0010, 16'h0000);
      push(1'b0, 1'b0, 16'h0010, 16'h0000);
      wait_done("cpu_read", 2'b01, 2);

      // DMA write 0x1234 to 0x0200.
      drive(1'b1, 1'b1, 16'h0200, 16'h1234);
      push(1'b1, 1'b1, 16'h0200, 16'h1234);
      wait_done("dma_write", 2'b10, 2);
      check("dma_write_mem", 32'(mem[10'h200]), 32'h1234);

      // Tie right after reset: CPU first, DMA next.
      pulse_reset();
      drive(1'b0, 1'b0, 16'h0020, 16'h0000);
      drive(1'b1, 1'b0, 16'h0030, 16'h0000);
      push(1'b0, 1'b0, 16'h0020, 16'h0000);
      push(1'b1, 1'b0, 16'h0030, 16'h0000);
      wait_done("tie_cpu", 2'b01, 2);
      wait_done("tie_dma", 2'b10, 2);

      // Both held for four transactions: strict alternation.
      drive(1'b0, 1'b1, 16'h0040, 16'h5555);
      drive(1'b1, 1'b0, 16'h0050, 16'h0000);
      push(1'b0, 1'b1, 16'h0040, 16'h5555);
      push(1'b1, 1'b0, 16'h0050, 16'h0000);
      push(1'b0, 1'b1, 16'h0040, 16'h5555);
      push(1'b1, 1'b0, 16'h0050, 16'h0000);
      wait_done("rr_t0", 2'b00, 2);
      wait_done("rr_t1", 2'b00, 2);
      wait_done("rr_t2", 2'b00, 2);
      wait_done("rr_t3", 2'b11, 2);

      // Reset in cycle 1 of a CPU write aborts it asynchronously.
      drive(1'b0, 1'b1, 16'h0060, 16'h7777);
      @(negedge Clk);
      check("abort_we_high", {30'd0, WE, OE}, 32'd2);
      cpu_req = 1'b0;
      #2 Reset = 1'b0;
      #1;
      check("abort_we_low",  {30'd0, WE, OE}, 32'd0);
      check("abort_busy",    32'(busy), 32'd0);
      check("abort_addr",    32'(ADDR), 32'd0);
      done_seen = 0;
      repeat (3) begin
         @(negedge Clk);
         if (cpu_done || dma_done) done_seen++;
      end
      check("abort_no_done", 32'(done_seen), 32'd0);
      Reset = 1'b1;
      exp_cpu_rd = 16'h0000;
      exp_dma_rd = 16'h0000;
      @(negedge Clk);
      check("abort_idle_busy", 32'(busy), 32'd0);
      check("abort_no_write", 32'(wr_ok[10'h060]), 32'd0);
      drive(1'b0, 1'b0, 16'h0010, 16'h0000);
      push(1'b0, 1'b0, 16'h0010, 16'h0000);
      wait_done("post_abort_read", 2'b01, 2);

      // ACCESS_CYCLES=4 instance: request dropped after grant still completes.
      pulse_reset();
      sel = 1'b1;
      drive(1'b0, 1'b0, 16'h0070, 16'h0000);
      push(1'b0, 1'b0, 16'h0070, 16'h0000);
      wait_done("ac4_read_drop", 2'b01, 4);

      check("sb_drained", 32'(sb_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
